// File: rtl/aer_transmitter.sv
// AER dual-rail transmitter: serialises one address event per frame as four-phase
// return-to-zero tokens (start, address MSB first, even parity, end) with a phase watchdog.
module aer_transmitter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ev_valid,
  input  logic [ADDR_W-1:0] ev_addr,
  output logic              ev_ready,
  output logic              ZERO_OUT,
  output logic              ONE_OUT,
  input  logic              ACK_IN,
  output logic              busy,
  output logic              err_timeout
);

  localparam int unsigned LastIdx = ADDR_W + 2;
  localparam int unsigned IdxW    = $clog2(LastIdx + 1);
  localparam int unsigned CntW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StDrive, StRelease, StFlush} state_e;

  state_e                 r_state, w_state_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_ack_s;
  logic [ADDR_W-1:0]      r_addr, w_addr_d;
  logic [IdxW-1:0]        r_idx, w_idx_d;
  logic [CntW-1:0]        r_cnt, w_cnt_d, w_cnt_inc;
  logic                   r_err, w_err_d;
  logic                   r_one, r_zero, w_one_d, w_zero_d;
  logic                   w_accept, w_drive, w_timeout;

  // Token value for a frame position: 1 selects the ONE rail, 0 the ZERO rail.
  function automatic logic tok_one(input logic [ADDR_W-1:0] addr, input logic [IdxW-1:0] idx);
    logic [ADDR_W-1:0] sh;
    sh = addr >> (IdxW'(ADDR_W) - idx);
    if (idx == '0) return 1'b1;
    if (idx <= IdxW'(ADDR_W)) return sh[0];
    if (idx == IdxW'(ADDR_W + 1)) return ^addr;
    return 1'b0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], ACK_IN};
  end

  assign w_ack_s   = r_sync[SYNC_STAGES-1];
  assign ev_ready  = (r_state == StIdle) && !w_ack_s;
  assign w_accept  = ev_valid && ev_ready;
  assign busy      = (r_state != StIdle);
  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_timeout = (w_cnt_inc == CntW'(TIMEOUT));

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_idx_d   = r_idx;
    w_cnt_d   = '0;
    w_err_d   = r_err;
    w_drive   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StDrive;
          w_addr_d  = ev_addr;
          w_idx_d   = '0;
          w_err_d   = 1'b0;
          w_drive   = 1'b1;
        end
      end
      StDrive: begin
        if (w_ack_s) begin
          w_state_d = StRelease;
        end else if (w_timeout) begin
          w_state_d = StFlush;
          w_err_d   = 1'b1;
        end else begin
          w_cnt_d = w_cnt_inc;
          w_drive = 1'b1;
        end
      end
      StRelease: begin
        if (!w_ack_s) begin
          if (r_idx != IdxW'(LastIdx)) begin
            w_idx_d   = r_idx + IdxW'(1);
            w_state_d = StDrive;
            w_drive   = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else if (w_timeout) begin
          w_state_d = StFlush;
          w_err_d   = 1'b1;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StFlush: begin
        if (!w_ack_s) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    w_one_d  = w_drive && tok_one(w_addr_d, w_idx_d);
    w_zero_d = w_drive && !tok_one(w_addr_d, w_idx_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_one   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
      r_one   <= w_one_d;
      r_zero  <= w_zero_d;
    end
  end

  assign ONE_OUT     = r_one;
  assign ZERO_OUT    = r_zero;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_aer_transmitter.sv
// Self-checking bench for aer_transmitter: constant frame table, corner-case sequences and
// a random-latency receiver whose decoded tokens are compared with a frame model.
module tb_aer_transmitter;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned FRAME   = ADDR_W + 3;
  localparam int          BOUND   = 3000;

  typedef enum int {MEcho, MSilent, MStuck, MRnd} mode_e;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [FRAME-1:0]  tokens;   // first token in the MSB
    int                cycles;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              ev_valid;
  logic [ADDR_W-1:0] ev_addr;
  logic              ev_ready;
  logic              zero_out, one_out;
  logic              ack_in;
  logic              busy;
  logic              err_timeout;

  mode_e mode = MEcho;
  logic  ack_reg;
  logic  stuck_release = 1'b0;
  logic  tok_q[$];
  logic  prev_any = 1'b0;
  int    overlap = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  assign ack_in = (mode == MEcho) ? (zero_out | one_out) : ack_reg;

  aer_transmitter #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ev_valid   (ev_valid),
    .ev_addr    (ev_addr),
    .ev_ready   (ev_ready),
    .ZERO_OUT   (zero_out),
    .ONE_OUT    (one_out),
    .ACK_IN     (ack_in),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  // Receiver models other than the zero-delay echo.
  initial begin
    int d;
    ack_reg = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        MStuck: begin
          if (stuck_release) ack_reg = 1'b0;
          else if (zero_out | one_out) ack_reg = 1'b1;
        end
        MRnd: begin
          if ((zero_out | one_out) != ack_reg) begin
            d = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 20));
            repeat (d) @(negedge clk);
            ack_reg = zero_out | one_out;
          end
        end
        default: ack_reg = 1'b0;
      endcase
    end
  end

  // Token decoder: a token is recorded when a rail rises from the all-zero spacer.
  always @(negedge clk) begin
    if (zero_out && one_out) overlap++;
    if (!prev_any && (zero_out || one_out)) tok_q.push_back(one_out);
    prev_any = zero_out || one_out;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [ADDR_W-1:0] a);
    int n = 0;
    while (!ev_ready && n < BOUND) begin
      tick();
      n++;
    end
    ev_addr  = a;
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ev_ready && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  // Expected frame: start ONE, address MSB first, even parity, end ZERO.
  function automatic logic [FRAME-1:0] model_frame(input logic [ADDR_W-1:0] a);
    logic [FRAME-1:0]  f;
    logic [ADDR_W-1:0] t;
    int                ones;
    f    = '0;
    f    = {f[FRAME-2:0], 1'b1};
    t    = a;
    ones = 0;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      f = {f[FRAME-2:0], t[ADDR_W-1]};
      if (t[ADDR_W-1]) ones++;
      t = t << 1;
    end
    f = {f[FRAME-2:0], (ones % 2) == 1};
    f = {f[FRAME-2:0], 1'b0};
    return f;
  endfunction

  function automatic logic [FRAME-1:0] got_frame(input int start);
    logic [FRAME-1:0] f;
    f = '0;
    for (int i = 0; i < int'(FRAME); i++)
      f = {f[FRAME-2:0], (start + i < tok_q.size()) ? tok_q[start + i] : 1'b0};
    return f;
  endfunction

  initial begin
    vec_t vecs[5];
    int   n;
    int   viol;
    logic [ADDR_W-1:0] a;

    vecs[0] = '{addr: 8'hA5, tokens: 11'b1_10100101_0_0, cycles: 66};
    vecs[1] = '{addr: 8'h01, tokens: 11'b1_00000001_1_0, cycles: 66};
    vecs[2] = '{addr: 8'hFF, tokens: 11'b1_11111111_0_0, cycles: 66};
    vecs[3] = '{addr: 8'h00, tokens: 11'b1_00000000_0_0, cycles: 66};
    vecs[4] = '{addr: 8'h80, tokens: 11'b1_10000000_1_0, cycles: 66};

    reset    = 1'b1;
    ev_valid = 1'b0;
    ev_addr  = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_zero", {31'd0, zero_out}, 32'd0);
    check("reset_one", {31'd0, one_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_err", {31'd0, err_timeout}, 32'd0);
    check("reset_ready", {31'd0, ev_ready}, 32'd1);

    // Echo receiver against constant frames.
    for (int v = 0; v < 5; v++) begin
      tok_q.delete();
      accept(vecs[v].addr);
      check("tbl_start_rail", {31'd0, one_out}, 32'd1);
      wait_ready(n);
      check("tbl_cycles", n, vecs[v].cycles);
      check("tbl_ntok", tok_q.size(), FRAME);
      check("tbl_tokens", {21'd0, got_frame(0)}, {21'd0, vecs[v].tokens});
      check("tbl_err", {31'd0, err_timeout}, 32'd0);
    end

    // ev_valid held high: the second frame starts only after returning to idle.
    tok_q.delete();
    ev_addr  = 8'h01;
    ev_valid = 1'b1;
    n = 0;
    while (!busy && n < BOUND) begin
      tick();
      n++;
    end
    viol = 0;
    n = 0;
    while (busy && n < BOUND) begin
      if (ev_ready) viol++;
      tick();
      n++;
    end
    check("held_len", n, 66);
    check("held_gap_idle", {31'd0, busy}, 32'd0);
    tick();
    check("held_restart", {31'd0, busy}, 32'd1);
    ev_valid = 1'b0;
    wait_ready(n);
    check("held_ready_low", viol, 0);
    check("held_ntok", tok_q.size(), 2 * FRAME);
    check("held_frame1", {21'd0, got_frame(0)}, {21'd0, model_frame(8'h01)});
    check("held_frame2", {21'd0, got_frame(FRAME)}, {21'd0, model_frame(8'h01)});

    // Silent receiver: the start rail times out.
    mode = MSilent;
    accept(8'h3C);
    check("silent_start", {31'd0, one_out}, 32'd1);
    n = 0;
    while (one_out && n < BOUND) begin
      tick();
      n++;
    end
    check("silent_high_cycles", n, TIMEOUT);
    check("silent_err", {31'd0, err_timeout}, 32'd1);
    tick();
    check("silent_idle", {31'd0, busy}, 32'd0);
    check("silent_ready", {31'd0, ev_ready}, 32'd1);
    mode = MEcho;
    tok_q.delete();
    accept(8'h5A);
    check("err_cleared", {31'd0, err_timeout}, 32'd0);
    wait_ready(n);
    check("after_err_tokens", {21'd0, got_frame(0)}, {21'd0, model_frame(8'h5A)});

    // ACK raised and never lowered: timeout in release, held in flush.
    stuck_release = 1'b0;
    mode = MStuck;
    tok_q.delete();
    accept(8'h80);
    n = 0;
    while (!err_timeout && n < BOUND) begin
      tick();
      n++;
    end
    check("stuck_err", {31'd0, err_timeout}, 32'd1);
    check("stuck_rails", {30'd0, zero_out, one_out}, 32'd0);
    check("stuck_ntok", tok_q.size(), 1);
    repeat (5) tick();
    check("stuck_held", {31'd0, busy}, 32'd1);
    stuck_release = 1'b1;
    n = 0;
    while (busy && n < BOUND) begin
      tick();
      n++;
    end
    check("stuck_exit_cycles", n, SYNC + 1);
    mode = MEcho;
    stuck_release = 1'b0;

    // Reset asserted while address token 4 is on the rails.
    tok_q.delete();
    accept(8'hC3);
    n = 0;
    while (tok_q.size() < 5 && n < BOUND) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    check("rst_mid_rails", {30'd0, zero_out, one_out}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_ready(n);
    check("rst_mid_ready", {31'd0, ev_ready}, 32'd1);
    tok_q.delete();
    accept(8'hC3);
    wait_ready(n);
    check("rst_new_frame", {21'd0, got_frame(0)}, {21'd0, model_frame(8'hC3)});

    // Random receiver latency over random addresses.
    mode = MRnd;
    for (int k = 0; k < 200; k++) begin
      a = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      tok_q.delete();
      accept(a);
      wait_ready(n);
      check("rnd_ready", {31'd0, ev_ready}, 32'd1);
      check("rnd_frame", {20'd0, tok_q.size() == FRAME, got_frame(0)},
            {20'd0, 1'b1, model_frame(a)});
    end
    check("rnd_err", {31'd0, err_timeout}, 32'd0);
    check("rails_exclusive", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
